// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the fetch front end and the control decoder.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] INSTR_BUBBLE = 32'h0;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FP     = 7'b1010011;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a combinational head, used for fetched words and PC tags.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN + ILEN,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: credit-limited in-order requests, PC tagging,
// wrong-path drop after redirect, and a valid/ready hand-off to decode.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]      pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        drop_cnt;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        tag_count;
  logic [CW:0]          credits_used;
  logic                 req_fire;
  logic                 resp_drop;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 tag_empty;
  logic                 tag_full;
  logic [XLEN-1:0]      resp_pc;
  logic [XLEN+ILEN-1:0] fifo_head;

  // A same-cycle pop frees its slot, which is what sustains one instruction per cycle.
  assign fifo_pop     = instr_valid && instr_ready;
  assign credits_used = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, fifo_pop};

  assign imem_req_valid = !rst && !redirect_valid && (credits_used < (CW + 1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (redirect_valid || (drop_cnt != '0));
  assign fifo_push = imem_resp_valid && !resp_drop;

  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? fifo_head[ILEN-1:0] : INSTR_BUBBLE;
  assign instr_pc    = instr_valid ? fifo_head[XLEN+ILEN-1:ILEN] : '0;

  // Tags track exactly the outstanding requests, so they survive redirects and
  // are retired by every response whether kept or dropped.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc),
    .pop       (imem_resp_valid),
    .flush     (1'b0),
    .head      (resp_pc),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  fetch_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(DEPTH)) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({resp_pc, imem_resp_data}),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        pc       <= word_align(redirect_pc);
        drop_cnt <= outstanding - CW'(imem_resp_valid);
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  a_no_full_push: assert property (@(posedge clk) disable iff (rst) fifo_push |-> !fifo_full);
  a_tag_match:    assert property (@(posedge clk) disable iff (rst) tag_count == outstanding);
  a_resp_tagged:  assert property (@(posedge clk) disable iff (rst) imem_resp_valid |-> !tag_empty);
  a_tag_room:     assert property (@(posedge clk) disable iff (rst) req_fire |-> !tag_full);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order memory model with configurable latency
// that returns the request address as the instruction word.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic out_is(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(instr_valid), 32'(v));
    chk({tag, "_pc"}, instr_pc, v ? pc : 32'h0);
    chk({tag, "_instr"}, instr, v ? pc : 32'h0);
  endtask

  // Drive this cycle's memory response, then let combinational outputs settle.
  task automatic settle();
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend_addr[0];
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
  endtask

  task automatic advance();
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
    end
    if (imem_resp_valid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (instr_valid && instr_ready)
      $display("cycle %0d: pop pc=%h instr=%h", cyc, instr_pc, instr);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    pend_addr.delete();
    pend_due.delete();
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_mem();
    #1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    out_is("rst", 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // Streaming with 1-cycle memory
    lat = 1;
    settle();
    chk("s0_req_valid", 32'(imem_req_valid), 32'h1);
    chk("s0_req_addr", imem_req_addr, 32'h0);
    out_is("s0", 1'b0, 32'h0);
    advance();
    settle(); out_is("s1", 1'b0, 32'h0); advance();
    for (int k = 2; k <= 5; k++) begin
      settle(); out_is("stream", 1'b1, 32'((k - 2) * 4)); advance();
    end

    // Backpressure: head holds, credits exhaust
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("bp_req_valid", 32'(imem_req_valid), 32'h0);
      out_is("bp", 1'b1, 32'h10);
      advance();
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle(); out_is("resume", 1'b1, 32'(16 + 4 * k)); advance();
    end

    // Redirect with two requests in flight, 3-cycle memory
    do_reset();
    lat = 3;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("r3_req_valid", 32'(imem_req_valid), 32'h1);
      chk("r3_req_addr", imem_req_addr, 32'(4 * k));
      advance();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    settle();
    chk("r3_redir_req_valid", 32'(imem_req_valid), 32'h0);
    advance();
    redirect_valid = 1'b0;
    settle();
    chk("r3_drain_req_valid", 32'(imem_req_valid), 32'h0);
    out_is("r3_c3", 1'b0, 32'h0);
    advance();
    settle();
    chk("r3_new_req_valid", 32'(imem_req_valid), 32'h1);
    chk("r3_new_req_addr", imem_req_addr, 32'h100);
    out_is("r3_c4", 1'b0, 32'h0);
    advance();
    settle(); chk("r3_next_req_addr", imem_req_addr, 32'h104); advance();
    settle(); out_is("r3_c6", 1'b0, 32'h0); advance();
    settle(); out_is("r3_c7", 1'b0, 32'h0); advance();
    settle(); out_is("r3_first", 1'b1, 32'h100); advance();
    settle(); out_is("r3_second", 1'b1, 32'h104); advance();

    // Redirect coincident with a response and a pop
    do_reset();
    lat = 1;
    settle(); advance();
    settle(); advance();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    settle();
    chk("rc_resp_coincident", 32'(imem_resp_valid), 32'h1);
    out_is("rc_pop", 1'b1, 32'h0);
    advance();
    redirect_valid = 1'b0;
    settle();
    chk("rc_req_valid", 32'(imem_req_valid), 32'h1);
    chk("rc_req_addr", imem_req_addr, 32'h200);
    out_is("rc_c3", 1'b0, 32'h0);
    advance();
    settle(); out_is("rc_c4", 1'b0, 32'h0); advance();
    settle(); out_is("rc_first", 1'b1, 32'h200); advance();
    settle(); out_is("rc_second", 1'b1, 32'h204); advance();

    // PC wrap
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    settle();
    chk("wr_redir_req_valid", 32'(imem_req_valid), 32'h0);
    advance();
    redirect_valid = 1'b0;
    settle(); chk("wr_req_addr_top", imem_req_addr, 32'hFFFF_FFFC); advance();
    settle(); chk("wr_req_addr_wrap", imem_req_addr, 32'h0); advance();
    settle(); out_is("wr_top", 1'b1, 32'hFFFF_FFFC); advance();
    settle(); out_is("wr_zero", 1'b1, 32'h0);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("ar_req_valid", 32'(imem_req_valid), 32'h0);
    out_is("ar", 1'b0, 32'h0);
    clear_mem();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    settle();
    chk("ar_restart_addr", imem_req_addr, 32'h0);
    chk("ar_restart_valid", 32'(imem_req_valid), 32'h1);
    advance();
    settle(); advance();
    settle(); out_is("ar_first", 1'b1, 32'h0); advance();
    settle(); out_is("ar_second", 1'b1, 32'h4); advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
